// File: rtl/fpga_burst_read_engine_if.sv
// Request/response bundle for fpga_burst_read_engine.
//
// Request side: per-channel valid/ready with packed start address and length.
//   req_valid  [NUM_CH]         requester -> engine
//   req_ready  [NUM_CH]         engine -> requester
//   req_addr   [NUM_CH*ADDR_W]  channel c at [c*ADDR_W +: ADDR_W]
//   req_len    [NUM_CH*LEN_W]   channel c at [c*LEN_W +: LEN_W]
// Read stream: backpressured beats tagged with owning channel and last flag.
//   rd_valid, rd_data, rd_last, rd_ch   engine -> consumer
//   rd_ready                            consumer -> engine
// master: requester/consumer side. slave: engine side.
interface fpga_burst_read_engine_if #(
   parameter int unsigned DATA_W = 256,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned LEN_W  = 7,
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned CH_W   = 1
);
   logic [NUM_CH-1:0]        req_valid;
   logic [NUM_CH-1:0]        req_ready;
   logic [NUM_CH*ADDR_W-1:0] req_addr;
   logic [NUM_CH*LEN_W-1:0]  req_len;
   logic                     rd_valid;
   logic                     rd_ready;
   logic [DATA_W-1:0]        rd_data;
   logic                     rd_last;
   logic [CH_W-1:0]          rd_ch;

   modport master (
      output req_valid, req_addr, req_len, rd_ready,
      input  req_ready, rd_valid, rd_data, rd_last, rd_ch
   );

   modport slave (
      input  req_valid, req_addr, req_len, rd_ready,
      output req_ready, rd_valid, rd_data, rd_last, rd_ch
   );
endinterface

// File: rtl/fpga_burst_read_engine.sv
// Multi-channel burst read engine over an on-chip token memory.
//
// A round-robin arbiter (active only while idle) accepts one (addr, len) request
// at a time; the engine then streams len consecutive words (address wraps at
// DEPTH) through a 2-entry output FIFO whose head registers drive the rd_* stream.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   wr_en/addr/data     memory preload write port, accepted in every state
//   bus (slave)         request handshake and read stream, see the interface
//   busy                high while a burst is being issued or drained
//   len_err             one-cycle pulse after a len==0 request is accepted
//   bursts_done         completed-burst counter, wraps at 2^32
module fpga_burst_read_engine #(
   parameter int unsigned DATA_W    = 256,
   parameter int unsigned DEPTH     = 65536,
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned MAX_BURST = 64,
   parameter int unsigned LEN_W     = 7,
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned CH_W      = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   fpga_burst_read_engine_if.slave bus,
   output logic                  busy,
   output logic                  len_err,
   output logic [31:0]           bursts_done
);

   typedef enum logic [1:0] {StIdle, StBurst, StDrain} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  issued_q, issued_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [CH_W-1:0]   rr_q, rr_d;
   logic [31:0]       bursts_q, bursts_d;
   logic              len_err_q, len_err_d;

   // Output FIFO: head entry drives the rd_* outputs directly.
   logic [1:0]        count_q, count_d;
   logic [DATA_W-1:0] head_data_q, tail_data_q;
   logic              head_last_q, tail_last_q;
   logic [CH_W-1:0]   head_ch_q, tail_ch_q;

   logic              found_hi, found_lo, grant_found;
   logic [CH_W-1:0]   ch_hi, ch_lo, grant_ch;
   logic [NUM_CH-1:0] req_ready;
   logic              handshake;
   logic [ADDR_W-1:0] sel_addr;
   logic [LEN_W-1:0]  sel_len, clamp_len;
   logic              issue, issue_last, pop;
   logic [ADDR_W-1:0] rd_addr;

   logic [DATA_W-1:0] mem [DEPTH];

   // ---------------------------------------------------------------------------
   // Round-robin arbiter. The first valid channel at or above rr_q wins; if none,
   // the lowest valid channel overall is exactly the wrapped-around winner.
   // ---------------------------------------------------------------------------
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      ch_hi    = '0;
      ch_lo    = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (!found_hi && bus.req_valid[c] && (CH_W'(c) >= rr_q)) begin
            found_hi = 1'b1;
            ch_hi    = CH_W'(c);
         end
         if (!found_lo && bus.req_valid[c]) begin
            found_lo = 1'b1;
            ch_lo    = CH_W'(c);
         end
      end
      grant_found = found_hi | found_lo;
      grant_ch    = found_hi ? ch_hi : ch_lo;
   end

   always_comb begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         req_ready[c] = !reset && (state_q == StIdle) && grant_found &&
                        (grant_ch == CH_W'(c));
      end
   end

   assign handshake = |(bus.req_valid & req_ready);
   assign sel_addr  = bus.req_addr[grant_ch*ADDR_W +: ADDR_W];
   assign sel_len   = bus.req_len[grant_ch*LEN_W +: LEN_W];
   assign clamp_len = (sel_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : sel_len;

   // ---------------------------------------------------------------------------
   // Read issue. The memory's 1-cycle read register is the FIFO entry itself, so
   // a read issued this cycle is already counted once it lands at the edge and
   // no separate in-flight term is needed.
   // ---------------------------------------------------------------------------
   assign issue      = (state_q == StBurst) && (issued_q != len_q) && (count_q != 2'd2);
   assign issue_last = (issued_q == len_q - LEN_W'(1));
   assign rd_addr    = addr_q + ADDR_W'(issued_q);
   assign pop        = (count_q != 2'd0) && bus.rd_ready;
   assign count_d    = count_q + {1'b0, issue} - {1'b0, pop};

   // ---------------------------------------------------------------------------
   // FSM next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      issued_d  = issued_q;
      ch_d      = ch_q;
      rr_d      = rr_q;
      bursts_d  = bursts_q;
      len_err_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (handshake) begin
               rr_d = (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
               if (sel_len == '0) begin
                  len_err_d = 1'b1;
               end else begin
                  addr_d   = sel_addr;
                  len_d    = clamp_len;
                  ch_d     = grant_ch;
                  issued_d = '0;
                  state_d  = StBurst;
               end
            end
         end
         StBurst: begin
            if (issue) begin
               issued_d = issued_q + LEN_W'(1);
               if (issue_last) state_d = StDrain;
            end
         end
         StDrain: begin
            if (pop && head_last_q) begin
               bursts_d = bursts_q + 32'd1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         len_q     <= '0;
         issued_q  <= '0;
         ch_q      <= '0;
         rr_q      <= '0;
         bursts_q  <= '0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         issued_q  <= issued_d;
         ch_q      <= ch_d;
         rr_q      <= rr_d;
         bursts_q  <= bursts_d;
         len_err_q <= len_err_d;
      end
   end

   // Memory write port. Contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Output FIFO. Reading mem here with non-blocking updates gives read-first
   // behaviour against a same-cycle write to the same address.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q     <= 2'd0;
         head_data_q <= '0;
         head_last_q <= 1'b0;
         head_ch_q   <= '0;
         tail_data_q <= '0;
         tail_last_q <= 1'b0;
         tail_ch_q   <= '0;
      end else begin
         count_q <= count_d;
         if (pop) begin
            if (count_q == 2'd2) begin
               head_data_q <= tail_data_q;
               head_last_q <= tail_last_q;
               head_ch_q   <= tail_ch_q;
            end else if (issue) begin
               head_data_q <= mem[rd_addr];
               head_last_q <= issue_last;
               head_ch_q   <= ch_q;
            end
         end else if (issue) begin
            if (count_q == 2'd0) begin
               head_data_q <= mem[rd_addr];
               head_last_q <= issue_last;
               head_ch_q   <= ch_q;
            end else begin
               tail_data_q <= mem[rd_addr];
               tail_last_q <= issue_last;
               tail_ch_q   <= ch_q;
            end
         end
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rd_valid  = (count_q != 2'd0);
   assign bus.rd_data   = head_data_q;
   assign bus.rd_last   = head_last_q;
   assign bus.rd_ch     = head_ch_q;
   assign busy          = (state_q != StIdle);
   assign len_err       = len_err_q;
   assign bursts_done   = bursts_q;

endmodule

// File: doc/fpga_burst_read_engine.md
Name: fpga_burst_read_engine

Overview:
- Multi-channel burst read engine over an on-chip token memory of DEPTH words, each DATA_W bits wide.
- NUM_CH requesters issue (address, length) burst requests over valid/ready.
- A round-robin arbiter grants one request at a time.
- The engine streams exactly `len` consecutive words, with wrap-around addressing, on a backpressured output stream tagged with channel id and last flag.
- Sits between the attention/KV fetch logic and token storage; a write port preloads the memory.

Parameters:
- DATA_W, 256: memory word and output data width in bits.
- DEPTH, 65536: number of memory words; must be a power of two.
- ADDR_W, 16: address width; must equal log2(DEPTH).
- MAX_BURST, 64: maximum beats per burst; longer requests are clamped.
- LEN_W, 7: request length width; must be at least log2(MAX_BURST)+1.
- NUM_CH, 2: number of requesting channels, 1..8.
- CH_W, 1: channel id width; must be at least max(1, log2(NUM_CH)).

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- wr_en, input, 1: memory write strobe.
- wr_addr, input, ADDR_W: write address.
- wr_data, input, DATA_W: write data.
- req_valid, input, NUM_CH: per-channel request valid.
- req_ready, output, NUM_CH: per-channel request accept.
- req_addr, input, NUM_CH*ADDR_W: start address; channel c occupies bits [c*ADDR_W +: ADDR_W].
- req_len, input, NUM_CH*LEN_W: burst length in beats, packed the same way as req_addr.
- rd_valid, output, 1: output beat valid.
- rd_ready, input, 1: downstream accept.
- rd_data, output, DATA_W: beat data.
- rd_last, output, 1: final beat of the burst.
- rd_ch, output, CH_W: channel that owns the beat.
- busy, output, 1: high in any state other than IDLE.
- len_err, output, 1: one-cycle pulse when a len==0 request is accepted.
- bursts_done, output, 32: count of completed bursts; wraps at 2^32.

Behaviour:
- Reset:
  - req_ready=0, rd_valid=0, rd_last=0, rd_data=0, rd_ch=0, busy=0, len_err=0, bursts_done=0.
  - State returns to IDLE, the output buffer is flushed, the in-flight read is discarded, and the RR pointer returns to channel 0.
  - Memory contents are not cleared.
  - A reset asserted mid-burst aborts the burst: no further beats, and bursts_done is not incremented.
- Memory:
  - Synchronous read with 1-cycle latency.
  - Writes are accepted in every state.
  - A read and a write to the same address in the same cycle returns the old data (read-first).
- Arbitration:
  - Only in IDLE. The grant goes to the first channel with req_valid=1, searching from the RR pointer upward with wrap.
  - req_ready is combinational: high only on the granted channel, and only in IDLE; at most one bit is high.
  - A handshake is req_valid[c] & req_ready[c]. On a handshake the RR pointer moves to (c+1) mod NUM_CH.
- Length rules:
  - len==0: the request is accepted and dropped; len_err pulses on the next cycle; state stays IDLE; no beats are produced and bursts_done is unchanged.
  - len>MAX_BURST: clamped to MAX_BURST.
- States:
  - IDLE: on a handshake with len>0, latch addr, clamped len and ch; go to BURST.
  - BURST: issue one memory read per cycle while (buffer occupancy + in-flight reads) < 2. Address = start + issued count, modulo DEPTH (natural ADDR_W wrap). When issued count == len, go to DRAIN.
  - DRAIN: wait until the final beat completes its handshake (rd_valid & rd_ready & rd_last), then increment bursts_done and go to IDLE. If that handshake occurs in the last BURST cycle, go straight to IDLE.
- Output buffer:
  - 2-entry FIFO driving registered rd_* outputs.
  - While rd_valid=1 and rd_ready=0, rd_data, rd_last and rd_ch hold stable.
  - No beat is lost or duplicated under any rd_ready pattern.
  - rd_last is 1 only on beat len-1; rd_ch equals the latched ch for every beat of the burst.
- Latency:
  - Request handshake at cycle T; first rd_valid at T+2.
  - With rd_ready held high, one beat per cycle thereafter.
  - Last beat at T+1+len. A new request can be accepted at the earliest on the cycle after the last-beat handshake.
- busy is high in BURST and DRAIN.

Test Plan:
- Preload mem[i]=i for i=0..127; ch0 req addr=10, len=4, rd_ready=1 -> rd_data 10,11,12,13 at T+2..T+5; rd_last only on 13; rd_ch=0; bursts_done=1.
- Wrap: ch1 req addr=DEPTH-2, len=4 -> data from addresses DEPTH-2, DEPTH-1, 0, 1; rd_ch=1.
- Backpressure: len=8, rd_ready toggled 1,0,0,1,0,1... -> exactly 8 beats, in order, with stable data while stalled; rd_last on beat 8 only.
- Arbitration: both channels hold req_valid with len=2 for 4 bursts -> grant order ch0, ch1, ch0, ch1; req_ready is never high on both channels at once.
- Edge lengths:
  - len=0 -> len_err pulse, no rd_valid, bursts_done unchanged.
  - len=100 -> exactly 64 beats.
- Reset at the 3rd beat of a len=16 burst -> all outputs are 0 next cycle and bursts_done=0. After reset, a new len=2 burst returns correct data, confirming the memory was preserved.
